// File: rtl/dbg_guv_cmd_tx.sv
// -----------------------------------------------------------------------------
// dbg_guv_cmd_tx
//
// Command transmitter for the head of the dbg_guv daisy chain. It packs a
// framed, backpressured host byte stream into one DATA_WIDTH command word and
// emits it as a single-cycle strobe. The chain controllers cannot apply
// backpressure, so the block also enforces a forced idle gap after each
// command.
//
// Ports
//   clk             sole clock
//   rst             synchronous, active-high reset
//   in_TDATA        host beat (IN_WIDTH bits)
//   in_TVALID       host beat valid
//   in_TREADY       beat accepted when in_TVALID && in_TREADY
//   in_TLAST        last beat of a command message
//   cmd_out_TDATA   last emitted command word (meaningful while TVALID=1)
//   cmd_out_TVALID  one-cycle command strobe, no backpressure
//   cmds_sent       count of emitted commands, wraps
//   err_overflow    one-cycle pulse: message longer than one word
//   err_timeout     one-cycle pulse: partial message discarded after idling
// -----------------------------------------------------------------------------
module dbg_guv_cmd_tx #(
  parameter int DATA_WIDTH = 64,
  parameter int IN_WIDTH   = 8,
  parameter int GAP        = 0,
  parameter int TIMEOUT    = 1023,
  parameter int CNT_SIZE   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_WIDTH-1:0]   in_TDATA,
  input  logic                  in_TVALID,
  output logic                  in_TREADY,
  input  logic                  in_TLAST,
  output logic [DATA_WIDTH-1:0] cmd_out_TDATA,
  output logic                  cmd_out_TVALID,
  output logic [CNT_SIZE-1:0]   cmds_sent,
  output logic                  err_overflow,
  output logic                  err_timeout
);

  localparam int B  = DATA_WIDTH / IN_WIDTH;
  localparam int KW = (B > 1) ? $clog2(B) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int GW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSEMBLE,
    S_SEND,
    S_GAP,
    S_DROP
  } state_e;

  state_e                state_q, state_d;
  logic [KW-1:0]         k_q,     k_d;
  logic [DATA_WIDTH-1:0] asm_q,   asm_d;
  logic [DATA_WIDTH-1:0] word_q,  word_d;
  logic                  ovf_q,   ovf_d;
  logic [TW-1:0]         idle_q,  idle_d;
  logic [GW-1:0]         gap_q,   gap_d;
  logic [CNT_SIZE-1:0]   cnt_q,   cnt_d;
  logic                  eovf_q,  eovf_d;
  logic                  eto_q,   eto_d;
  logic                  accept;

  // Ready depends only on state (and reset), never on in_TVALID.
  assign in_TREADY = !rst && (state_q inside {S_IDLE, S_ASSEMBLE, S_DROP});
  assign accept    = in_TVALID && in_TREADY;

  assign cmd_out_TDATA  = word_q;
  assign cmd_out_TVALID = (state_q == S_SEND);
  assign cmds_sent      = cnt_q;
  assign err_overflow   = eovf_q;
  assign err_timeout    = eto_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    k_d     = k_q;
    asm_d   = asm_q;
    word_d  = word_q;
    ovf_d   = ovf_q;
    idle_d  = idle_q;
    gap_d   = gap_q;
    cnt_d   = cnt_q;
    eovf_d  = 1'b0;
    eto_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          // A new message starts from a cleared word so unfilled beats read 0.
          asm_d                 = '0;
          asm_d[IN_WIDTH-1:0]   = in_TDATA;
          k_d                   = KW'(1);
          idle_d                = '0;
          if (in_TLAST || B == 1) begin
            state_d = S_SEND;
            ovf_d   = (B == 1) && !in_TLAST;
          end else begin
            state_d = S_ASSEMBLE;
          end
        end
      end

      S_ASSEMBLE: begin
        if (accept) begin
          asm_d[int'(k_q) * IN_WIDTH +: IN_WIDTH] = in_TDATA;
          k_d    = k_q + KW'(1);
          idle_d = '0;
          if (in_TLAST) begin
            state_d = S_SEND;
          end else if (k_q == KW'(B - 1)) begin
            // Word is full but the message continues: emit it, drop the rest.
            state_d = S_SEND;
            ovf_d   = 1'b1;
          end
        end else if (TIMEOUT != 0 && idle_q == TW'(TIMEOUT - 1)) begin
          // TIMEOUT complete idle cycles since the last beat: abandon the word.
          state_d = S_IDLE;
          k_d     = '0;
          eto_d   = 1'b1;
        end else begin
          idle_d = idle_q + TW'(1);
        end
      end

      S_SEND: begin
        gap_d = '0;
        if (GAP > 0) state_d = S_GAP;
        else         state_d = ovf_q ? S_DROP : S_IDLE;
      end

      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = ovf_q ? S_DROP : S_IDLE;
        else                       gap_d   = gap_q + GW'(1);
      end

      S_DROP: begin
        if (accept && in_TLAST) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Entry actions shared by every path into SEND / DROP.
    if (state_d == S_SEND) begin
      word_d = asm_d;
      cnt_d  = cnt_q + CNT_SIZE'(1);
    end
    if (state_d == S_DROP && state_q != S_DROP) begin
      eovf_d = 1'b1;
      ovf_d  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      // NOTE: the assembly word is reset too although each message clears it;
      // it keeps the register free of X after reset at negligible cost.
      asm_q   <= '0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
      idle_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      eovf_q  <= 1'b0;
      eto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
      idle_q  <= idle_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      eovf_q  <= eovf_d;
      eto_q   <= eto_d;
    end
  end

endmodule

// File: tb/tb_dbg_guv_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_dbg_guv_cmd_tx
//
// Two instances share one host stream: dut0 (GAP=0, TIMEOUT=4) and dut1
// (GAP=2, TIMEOUT=1023). 'sel' routes TVALID to one instance and muxes its
// outputs onto the observed m_* signals.
// -----------------------------------------------------------------------------
module tb_dbg_guv_cmd_tx;

  typedef struct packed {
    int          len;
    logic [95:0] beats;     // beat k at [8k +: 8]
    int          bubble;    // idle cycles between beats
    logic [63:0] exp_word;
    logic        exp_ovf;
  } vec_t;

  logic        clk, rst, sel;
  logic [7:0]  tdata;
  logic        tvalid, tlast;
  logic        v_in0, v_in1;
  logic        r0, r1, v0, v1, o0, t0, o1, t1;
  logic [63:0] d0, d1;
  logic [15:0] c0, c1;
  logic        m_ready, m_valid, m_eovf, m_eto;
  logic [63:0] m_data;
  logic [15:0] m_cnt;
  int          gap_sel;

  int checks, errors;
  int cyc, n_strobe, n_ovf, n_to, last_cyc, prev_cyc;
  bit have_strobe, sb_en;
  logic [63:0] last_data;
  logic [63:0] exp_q[$];
  int exp_cnt[2];

  assign v_in0   = tvalid && !sel;
  assign v_in1   = tvalid && sel;
  assign m_ready = sel ? r1 : r0;
  assign m_valid = sel ? v1 : v0;
  assign m_data  = sel ? d1 : d0;
  assign m_cnt   = sel ? c1 : c0;
  assign m_eovf  = sel ? o1 : o0;
  assign m_eto   = sel ? t1 : t0;
  assign gap_sel = sel ? 2 : 0;

  dbg_guv_cmd_tx #(.DATA_WIDTH(64), .IN_WIDTH(8), .GAP(0), .TIMEOUT(4), .CNT_SIZE(16)) dut0 (
    .clk(clk), .rst(rst), .in_TDATA(tdata), .in_TVALID(v_in0), .in_TREADY(r0),
    .in_TLAST(tlast), .cmd_out_TDATA(d0), .cmd_out_TVALID(v0), .cmds_sent(c0),
    .err_overflow(o0), .err_timeout(t0));

  dbg_guv_cmd_tx #(.DATA_WIDTH(64), .IN_WIDTH(8), .GAP(2), .TIMEOUT(1023), .CNT_SIZE(16)) dut1 (
    .clk(clk), .rst(rst), .in_TDATA(tdata), .in_TVALID(v_in1), .in_TREADY(r1),
    .in_TLAST(tlast), .cmd_out_TDATA(d1), .cmd_out_TVALID(v1), .cmds_sent(c1),
    .err_overflow(o1), .err_timeout(t1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: strobe bookkeeping, scoreboard and protocol invariants.
  always @(negedge clk) begin
    cyc++;
    if (m_valid === 1'b1) begin
      n_strobe++;
      if (have_strobe) check("strobe_spacing", 64'((cyc - last_cyc) >= gap_sel + 2), 64'd1);
      prev_cyc    = last_cyc;
      last_cyc    = cyc;
      have_strobe = 1'b1;
      last_data   = m_data;
      if (sb_en) begin
        check("sb_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check("sb_word", m_data, exp_q.pop_front());
      end
    end
    if (m_eovf === 1'b1) n_ovf++;
    if (m_eto === 1'b1) n_to++;
    if (m_valid === 1'b1 || m_eto === 1'b1)
      check("valid_with_timeout", 64'(m_valid && m_eto), 64'd0);
  end

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the selected DUT accepts it.
  task automatic drive_beat(input logic [7:0] d, input logic last);
    int n;
    n      = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    @(negedge clk);
    while (m_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check("beat_accept", 64'(m_ready), 64'd1);
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic send_msg(input logic [95:0] beats, input int len, input int bubble);
    for (int k = 0; k < len; k++) begin
      drive_beat(beats[8*k +: 8], k == len - 1);
      if (bubble > 0 && k < len - 1) idle(bubble);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int s, o;
    s = n_strobe;
    o = n_ovf;
    send_msg(v.beats, v.len, v.bubble);
    exp_cnt[sel]++;
    if (!v.exp_ovf) begin
      @(negedge clk);
      check("latency_valid", 64'(m_valid), 64'd1);
      check("latency_data", m_data, v.exp_word);
      check("latency_cnt", 64'(m_cnt), 64'(exp_cnt[sel] % 65536));
      @(negedge clk);
      check("single_strobe", 64'(m_valid), 64'd0);
    end
    idle(2);
    check("vec_strobes", 64'(n_strobe - s), 64'd1);
    check("vec_word", last_data, v.exp_word);
    check("vec_ovf", 64'(n_ovf - o), 64'(v.exp_ovf));
    check("vec_cnt", 64'(m_cnt), 64'(exp_cnt[sel] % 65536));
  endtask

  initial begin
    vec_t        vecs[7];
    vec_t        v;
    int          s, o, pulse_at, len, exp_ovf;
    logic [95:0] bts;
    logic [63:0] w;

    vecs[0] = '{len: 8,  beats: 96'h0807060504030201,         bubble: 0,
                exp_word: 64'h0807060504030201, exp_ovf: 1'b0};
    vecs[1] = '{len: 3,  beats: 96'hCCBBAA,                   bubble: 0,
                exp_word: 64'h0000000000CCBBAA, exp_ovf: 1'b0};
    vecs[2] = '{len: 1,  beats: 96'h11,                       bubble: 0,
                exp_word: 64'h0000000000000011, exp_ovf: 1'b0};
    vecs[3] = '{len: 10, beats: 96'h2A29_2827262524232221,    bubble: 0,
                exp_word: 64'h2827262524232221, exp_ovf: 1'b1};
    vecs[4] = '{len: 1,  beats: 96'h5A,                       bubble: 0,
                exp_word: 64'h000000000000005A, exp_ovf: 1'b0};
    vecs[5] = '{len: 7,  beats: 96'hF7F6F5F4F3F2F1,           bubble: 3,
                exp_word: 64'h00F7F6F5F4F3F2F1, exp_ovf: 1'b0};
    vecs[6] = '{len: 9,  beats: 96'h99_9897969594939291,      bubble: 0,
                exp_word: 64'h9897969594939291, exp_ovf: 1'b1};

    checks = 0; errors = 0; cyc = 0; n_strobe = 0; n_ovf = 0; n_to = 0;
    last_cyc = 0; prev_cyc = 0; have_strobe = 1'b0; sb_en = 1'b0;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    sel = 1'b0; tvalid = 1'b0; tlast = 1'b0; tdata = '0;

    // Reset values.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", 64'(m_ready), 64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_data", m_data, 64'd0);
    check("rst_cnt", 64'(m_cnt), 64'd0);
    check("rst_errs", 64'({m_eovf, m_eto}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(m_ready), 64'd1);
    @(posedge clk);
    #1;

    // Table of messages on dut0 (GAP=0).
    for (int i = 0; i < 7; i++) apply_vec(vecs[i]);

    // Timeout on dut0 (TIMEOUT=4): two beats then silence.
    s = n_strobe;
    o = n_to;
    drive_beat(8'h61, 1'b0);
    drive_beat(8'h62, 1'b0);
    pulse_at = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (m_eto === 1'b1 && pulse_at == 0) pulse_at = i;
    end
    @(posedge clk);
    #1;
    check("to_pulse_cycle", 64'(pulse_at), 64'd5);
    check("to_pulse_count", 64'(n_to - o), 64'd1);
    check("to_no_strobe", 64'(n_strobe - s), 64'd0);
    check("to_cnt", 64'(m_cnt), 64'(exp_cnt[0] % 65536));
    v = '{len: 8, beats: 96'h8887868584838281, bubble: 0,
          exp_word: 64'h8887868584838281, exp_ovf: 1'b0};
    apply_vec(v);

    // Forced gap on dut1 (GAP=2) with TVALID held high.
    idle(6);
    sel = 1'b1;
    idle(2);
    drive_beat(8'h41, 1'b1);
    tvalid = 1'b1; tdata = 8'h42; tlast = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("gap_ready_low_1", 64'(m_ready), 64'd0);
    end
    @(negedge clk);
    check("gap_ready_back_1", 64'(m_ready), 64'd1);
    @(posedge clk);
    #1 tvalid = 1'b0; tlast = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("gap_ready_low_2", 64'(m_ready), 64'd0);
    end
    @(negedge clk);
    check("gap_ready_back_2", 64'(m_ready), 64'd1);
    @(posedge clk);
    #1;
    exp_cnt[1] += 2;
    check("gap_strobe_distance", 64'(last_cyc - prev_cyc), 64'd4);
    check("gap_second_word", last_data, 64'h42);
    check("gap_cnt", 64'(m_cnt), 64'(exp_cnt[1] % 65536));

    // Randomized messages on dut1 against the scoreboard model.
    sb_en   = 1'b1;
    o       = n_ovf;
    exp_ovf = 0;
    for (int m = 0; m < 30; m++) begin
      len = $urandom_range(1, 11);
      bts = '0;
      w   = '0;
      for (int k = 0; k < len; k++) bts[8*k +: 8] = 8'($urandom);
      for (int k = 0; k < len && k < 8; k++) w[8*k +: 8] = bts[8*k +: 8];
      if (len > 8) exp_ovf++;
      exp_q.push_back(w);
      exp_cnt[1]++;
      for (int k = 0; k < len; k++) begin
        drive_beat(bts[8*k +: 8], k == len - 1);
        if (k < len - 1) begin
          s = $urandom_range(0, 2);
          if (s > 0) idle(s);
        end
      end
      s = $urandom_range(0, 3);
      if (s > 0) idle(s);
    end
    idle(12);
    sb_en = 1'b0;
    check("rand_all_emitted", 64'(exp_q.size()), 64'd0);
    check("rand_ovf", 64'(n_ovf - o), 64'(exp_ovf));
    check("rand_cnt", 64'(m_cnt), 64'(exp_cnt[1] % 65536));

    // Reset in the middle of a message on dut0.
    idle(6);
    sel = 1'b0;
    idle(2);
    s = n_strobe;
    for (int k = 0; k < 5; k++) drive_beat(8'hB1 + 8'(k), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready_low", 64'(m_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("mid_rst_valid", 64'(m_valid), 64'd0);
    check("mid_rst_data", m_data, 64'd0);
    check("mid_rst_cnt", 64'(m_cnt), 64'd0);
    check("mid_rst_errs", 64'({m_eovf, m_eto}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    idle(6);
    check("mid_rst_no_strobe", 64'(n_strobe - s), 64'd0);
    v = '{len: 3, beats: 96'h737271, bubble: 0,
          exp_word: 64'h0000000000737271, exp_ovf: 1'b0};
    apply_vec(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
